seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the team's two-digit multiplexed seven-segment driver. Samples the shared segment bus and digit-select line, waits for each displayed pattern to settle, decodes it back to a hex nibble and reassembles the upper/lower digit pair. Used in self-checking display paths and board-level loopback, where the scanned display bus is read back into the fabric.

## Interface
- SETTLE, 8: consecutive identical samples beyond the first needed before a pattern is captured (≥2)
- CNT_BITS, 4: width of settle counter; must hold SETTLE-1
- TIMEOUT, 16000: cycles without a completed pair before link_up drops
- TO_BITS, 15: width of timeout counter; must hold TIMEOUT
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- seg_in  in  7  segment bus {g,f,e,d,c,b,a}, active-high
- sel_in  in  1  digit select; 1 = upper digit displayed, 0 = lower
- digit_hi  out  4  last committed upper nibble
- digit_lo  out  4  last committed lower nibble
- pair_valid  out  1  one-cycle pulse when digit_hi/digit_lo update
- seg_err  out  1  one-cycle pulse on capture of an undecodable pattern
- link_up  out  1  level; a pair has completed recently

## Operation
- Decode (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71. 00 = blank. Anything else = invalid.
- Sampler: register s_reg <= {sel_in,seg_in} every cycle. If incoming ≠ s_reg: cnt<=0, captured<=0. Else if cnt<SETTLE-1: cnt++. Else if !captured: capture event, captured<=1. Exactly one capture per stable interval.
- FSM, states WAIT_HI, WAIT_LO, evaluated only on capture:
  - WAIT_HI: sel=1 and valid → hi_tmp<=nibble, go WAIT_LO. sel=0 valid → ignored, stay.
  - WAIT_LO: sel=0 and valid → digit_hi<=hi_tmp, digit_lo<=nibble, pair_valid pulse, go WAIT_HI. sel=1 valid → hi_tmp overwritten, stay.
  - Any state, blank → go WAIT_HI, no error. Invalid → go WAIT_HI, seg_err pulse, partial pair discarded.
- digit_hi/digit_lo change only with pair_valid; never partially updated.
- link_up set on pair_valid; cleared per Configuration.

## Timing
- Reset: digit_hi=0, digit_lo=0, pair_valid=0, seg_err=0, link_up=0, state WAIT_HI, s_reg=0, cnt=0, captured=0, timeout count=0.
- New value first sampled at edge E0; capture at edge E(SETTLE) if held through it; pair_valid/seg_err high for the cycle after E(SETTLE).
- Any change before E(SETTLE) restarts from E0 at the changing edge; glitches shorter than SETTLE+1 samples are never captured.
- sel_in and seg_in changing on the same edge count as one change.
- Pattern held indefinitely: one capture only; re-capture requires an intervening change.
- rst mid-pair: partial hi_tmp discarded, all outputs to reset values on the next edge.
- pair_valid and seg_err never assert in the same cycle.

## Configuration
- SEGDEC_TIMEOUT_EN defined: timeout counter increments each cycle, saturating at TIMEOUT; cleared on pair_valid (pair_valid wins over saturation). Reaching TIMEOUT clears link_up on that edge. digit_hi/digit_lo retained.
- Not defined: no timeout counter; link_up set by first pair_valid, held until rst.

## Test plan
- SETTLE=8: sel=1,seg=0x4F for 20 cycles, then sel=0,seg=0x7C for 20 → pair_valid single pulse exactly 9 edges after the 0x7C change, digit_hi=3, digit_lo=B, link_up=1.
- Glitch: during lower digit insert seg=0x06 for 5 cycles then back → no extra capture; pair_valid only after full settle of final value.
- Invalid: sel=1,0x4F settled, then sel=0,0x55 settled → seg_err one pulse, no pair_valid, digits unchanged; following valid hi/lo pair commits normally.
- Blank and ordering: reset with bus 0x00 → no seg_err, no pair_valid; lower digit alone (sel=0,0x3F) → ignored; hi 0x07 twice-overwritten by 0x7F then lo 0x3F → digit_hi=8, digit_lo=0.
- SEGDEC_TIMEOUT_EN, TIMEOUT=64: complete pair then hold bus constant → link_up falls exactly 64 edges after the pair_valid edge; next pair reasserts it. Without macro, link_up stays 1.
- rst asserted while in WAIT_LO → all outputs zero next cycle; subsequent lo capture does not commit.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of the two-digit multiplexed seven-segment bus: debounce, decode, pair up.
// Optional link timeout is enabled with `define SEGDEC_TIMEOUT_EN.
module seg_scan_decoder #(
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned CNT_BITS = 4,
  parameter int unsigned TIMEOUT  = 16000,
  parameter int unsigned TO_BITS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       sel_in,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic       pair_valid,
  output logic       seg_err,
  output logic       link_up
);

  typedef enum logic [0:0] {StWaitHi, StWaitLo} state_e;

  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(SETTLE - 1);

  // Sampler and settle detection
  logic [7:0]          sample_in;
  logic [7:0]          s_reg;
  logic [CNT_BITS-1:0] cnt_q;
  logic                captured_q;
  logic                capture;

  assign sample_in = {sel_in, seg_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg      <= 8'h00;
      cnt_q      <= '0;
      captured_q <= 1'b0;
    end else begin
      s_reg <= sample_in;
      if (sample_in != s_reg) begin
        cnt_q      <= '0;
        captured_q <= 1'b0;
      end else if (cnt_q < CntMax) begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end else if (!captured_q) begin
        captured_q <= 1'b1;
      end
    end
  end

  // One capture per stable interval: the edge where the count is full and nothing was taken yet
  assign capture = (sample_in == s_reg) && (cnt_q >= CntMax) && !captured_q;

  // Pattern decode of the settled sample
  logic [3:0] nib;
  logic       seg_valid;
  logic       seg_blank;

  always_comb begin
    nib       = 4'h0;
    seg_valid = 1'b1;
    seg_blank = 1'b0;
    case (s_reg[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      7'h00: begin
        seg_valid = 1'b0;
        seg_blank = 1'b1;
      end
      default: seg_valid = 1'b0;
    endcase
  end

  // Pairing FSM
  state_e     state_q, state_d;
  logic [3:0] hi_tmp_q, hi_tmp_d;
  logic [3:0] digit_hi_q, digit_hi_d;
  logic [3:0] digit_lo_q, digit_lo_d;
  logic       pair_valid_q, pair_valid_d;
  logic       seg_err_q, seg_err_d;
  logic       link_up_q, link_up_d;

  always_comb begin
    state_d      = state_q;
    hi_tmp_d     = hi_tmp_q;
    digit_hi_d   = digit_hi_q;
    digit_lo_d   = digit_lo_q;
    pair_valid_d = 1'b0;
    seg_err_d    = 1'b0;
    if (capture) begin
      if (seg_blank) begin
        state_d = StWaitHi;
      end else if (!seg_valid) begin
        state_d   = StWaitHi;
        seg_err_d = 1'b1;
      end else begin
        case (state_q)
          StWaitHi: begin
            if (s_reg[7]) begin
              hi_tmp_d = nib;
              state_d  = StWaitLo;
            end
          end
          StWaitLo: begin
            if (s_reg[7]) begin
              hi_tmp_d = nib;
            end else begin
              digit_hi_d   = hi_tmp_q;
              digit_lo_d   = nib;
              pair_valid_d = 1'b1;
              state_d      = StWaitHi;
            end
          end
          default: state_d = StWaitHi;
        endcase
      end
    end
  end

`ifdef SEGDEC_TIMEOUT_EN
  localparam logic [TO_BITS-1:0] ToMax = TO_BITS'(TIMEOUT);

  logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;

  // A commit on the same edge as saturation keeps the link up
  always_comb begin
    link_up_d = link_up_q;
    to_cnt_d  = to_cnt_q;
    if (pair_valid_d) begin
      to_cnt_d  = '0;
      link_up_d = 1'b1;
    end else begin
      to_cnt_d = (to_cnt_q == ToMax) ? ToMax : to_cnt_q + TO_BITS'(1);
      if (to_cnt_d == ToMax) begin
        link_up_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  always_comb begin
    link_up_d = link_up_q | pair_valid_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StWaitHi;
      hi_tmp_q     <= 4'h0;
      digit_hi_q   <= 4'h0;
      digit_lo_q   <= 4'h0;
      pair_valid_q <= 1'b0;
      seg_err_q    <= 1'b0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_tmp_q     <= hi_tmp_d;
      digit_hi_q   <= digit_hi_d;
      digit_lo_q   <= digit_lo_d;
      pair_valid_q <= pair_valid_d;
      seg_err_q    <= seg_err_d;
      link_up_q    <= link_up_d;
    end
  end

  assign digit_hi   = digit_hi_q;
  assign digit_lo   = digit_lo_q;
  assign pair_valid = pair_valid_q;
  assign seg_err    = seg_err_q;
  assign link_up    = link_up_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder; expected pair/error events are queued as stimulus is driven.
module tb_seg_scan_decoder;

`ifdef SEGDEC_TIMEOUT_EN
  localparam int unsigned TimeoutCyc = 64;
  localparam int unsigned ToBits     = 7;
`else
  localparam int unsigned TimeoutCyc = 16000;
  localparam int unsigned ToBits     = 15;
`endif

  typedef struct {
    logic       err;
    logic [3:0] hi;
    logic [3:0] lo;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic       sel_in = 1'b0;
  logic [3:0] digit_hi, digit_lo;
  logic       pair_valid, seg_err, link_up;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t e;

  seg_scan_decoder #(
    .SETTLE  (8),
    .CNT_BITS(4),
    .TIMEOUT (TimeoutCyc),
    .TO_BITS (ToBits)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .sel_in    (sel_in),
    .digit_hi  (digit_hi),
    .digit_lo  (digit_lo),
    .pair_valid(pair_valid),
    .seg_err   (seg_err),
    .link_up   (link_up)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [6:0] g, input int n);
    @(negedge clk);
    sel_in = s;
    seg_in = g;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_pair(input logic [3:0] hi, input logic [3:0] lo);
    exp_q.push_back('{err: 1'b0, hi: hi, lo: lo});
  endtask

  task automatic expect_err();
    exp_q.push_back('{err: 1'b1, hi: 4'h0, lo: 4'h0});
  endtask

  // Every output event is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (pair_valid || seg_err)) begin
      check_val("pulse_exclusive", {31'd0, pair_valid & seg_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_event", {30'd0, pair_valid, seg_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("event_kind", {31'd0, seg_err}, {31'd0, e.err});
        if (!e.err) begin
          check_val("pair_hi", {28'd0, digit_hi}, {28'd0, e.hi});
          check_val("pair_lo", {28'd0, digit_lo}, {28'd0, e.lo});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fall_at;
    int pv_at;

    // Reset with a blank bus
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outputs", {21'd0, digit_hi, digit_lo, pair_valid, seg_err, link_up}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("blank_no_link", {31'd0, link_up}, 32'd0);

    // Lower digit alone is ignored
    drive(1'b0, 7'h3F, 20);
    #1;
    check_val("lo_alone_digits", {24'd0, digit_hi, digit_lo}, 32'd0);

    // Basic pair with exact commit latency
    expect_pair(4'h3, 4'hB);
    drive(1'b1, 7'h4F, 20);
    @(negedge clk);
    sel_in = 1'b0;
    seg_in = 7'h7C;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) check_val("pv_early", {31'd0, pair_valid}, 32'd0);
      if (k == 9) check_val("pv_latency", {31'd0, pair_valid}, 32'd1);
    end
    @(posedge clk);
    #1;
    check_val("pv_single", {31'd0, pair_valid}, 32'd0);
    check_val("pair1_digits", {24'd0, digit_hi, digit_lo}, 32'h3B);
    check_val("pair1_link", {31'd0, link_up}, 32'd1);
    repeat (40) @(posedge clk);

    // Short lower value and glitch are not captured
    expect_pair(4'h3, 4'h9);
    drive(1'b1, 7'h4F, 20);
    drive(1'b0, 7'h6F, 3);
    drive(1'b0, 7'h06, 5);
    drive(1'b0, 7'h6F, 20);
    #1;
    check_val("glitch_digits", {24'd0, digit_hi, digit_lo}, 32'h39);

    // Invalid lower pattern discards the pair
    expect_err();
    drive(1'b1, 7'h4F, 20);
    drive(1'b0, 7'h55, 20);
    #1;
    check_val("invalid_digits", {24'd0, digit_hi, digit_lo}, 32'h39);
    expect_pair(4'h2, 4'h4);
    drive(1'b1, 7'h5B, 20);
    drive(1'b0, 7'h66, 20);
    #1;
    check_val("after_err_digits", {24'd0, digit_hi, digit_lo}, 32'h24);

    // Upper digit overwritten twice before the lower one
    expect_pair(4'h8, 4'h0);
    drive(1'b1, 7'h07, 20);
    drive(1'b1, 7'h7D, 20);
    drive(1'b1, 7'h7F, 20);
    drive(1'b0, 7'h3F, 20);
    #1;
    check_val("overwrite_digits", {24'd0, digit_hi, digit_lo}, 32'h80);

    // Blank between halves drops the partial pair without error
    drive(1'b1, 7'h39, 20);
    drive(1'b1, 7'h00, 20);
    drive(1'b0, 7'h5E, 20);
    #1;
    check_val("blank_mid_digits", {24'd0, digit_hi, digit_lo}, 32'h80);

    // Link hold / timeout measured from the pair_valid edge
    expect_pair(4'hA, 4'hF);
    drive(1'b1, 7'h77, 20);
    @(negedge clk);
    sel_in = 1'b0;
    seg_in = 7'h71;
    pv_at = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (pair_valid) begin
        pv_at = k;
        break;
      end
    end
    check_val("to_pair_seen", pv_at, 32'd9);
    fall_at = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (!link_up && fall_at < 0) fall_at = k;
    end
`ifdef SEGDEC_TIMEOUT_EN
    check_val("link_fall_edge", fall_at, 32'd64);
`else
    check_val("link_held", fall_at, 32'hFFFF_FFFF);
`endif
    check_val("to_digits_kept", {24'd0, digit_hi, digit_lo}, 32'hAF);
    expect_pair(4'hC, 4'hD);
    drive(1'b1, 7'h39, 20);
    drive(1'b0, 7'h5E, 12);
    #1;
    check_val("link_reassert", {31'd0, link_up}, 32'd1);

    // Reset while waiting for the lower digit
    drive(1'b1, 7'h06, 20);
    @(negedge clk);
    rst    = 1'b1;
    sel_in = 1'b0;
    seg_in = 7'h3F;
    @(posedge clk);
    #1;
    check_val("rst_mid_outputs", {21'd0, digit_hi, digit_lo, pair_valid, seg_err, link_up}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_val("rst_no_commit", {23'd0, digit_hi, digit_lo, pair_valid}, 32'd0);

    repeat (5) @(posedge clk);
    check_val("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
